// File: rtl/led_status_bank_pkg.sv
// Shared definitions for the status-LED bank: mode encodings, channel FSM states
// and helpers mapping a mode (or state) to its entry state (or LED level).
package led_status_bank_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_FLASH = 2'b10,
        LED_CODE  = 2'b11
    } led_mode_e;

    typedef enum logic [2:0] {
        CH_IDLE,
        CH_STEADY_OFF,
        CH_STEADY_ON,
        CH_FL_ON,
        CH_FL_OFF,
        CH_CD_ON,
        CH_CD_OFF,
        CH_CD_GAP
    } ch_state_e;

    // The pause after a blink code lasts this many half-periods.
    localparam int GAP_MULT = 4;

    function automatic logic state_lit(ch_state_e s);
        return (s == CH_STEADY_ON) || (s == CH_FL_ON) || (s == CH_CD_ON);
    endfunction

    function automatic ch_state_e entry_state(led_mode_e m, logic code_zero);
        case (m)
            LED_OFF:   return CH_STEADY_OFF;
            LED_ON:    return CH_STEADY_ON;
            LED_FLASH: return CH_FL_ON;
            default:   return code_zero ? CH_STEADY_OFF : CH_CD_ON;
        endcase
    endfunction

endpackage

// File: rtl/led_status_bank_channel.sv
// One LED channel: steady, flash or blink-code pattern advanced by the shared tick.
// The lit output is registered from the state being entered on each edge.
module led_channel
    import led_status_bank_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int CODE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  divider,
    input  logic [CODE_W-1:0] code,
    input  logic              tick,
    input  logic              sync,
    output logic              lit
);

    localparam logic [DIV_W+1:0] GAP_K = (DIV_W+2)'(GAP_MULT);

    ch_state_e         state;
    ch_state_e         entry;
    led_mode_e         mode_q;
    led_mode_e         mode_in;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  d_eff;
    logic [DIV_W-1:0]  d_last;
    logic [CODE_W-1:0] blink;
    logic [CODE_W-1:0] code_q;
    logic [DIV_W+1:0]  gap;
    logic [DIV_W+1:0]  gap_last;
    logic              phase_done;
    logic              code_zero;

    assign mode_in    = led_mode_e'(mode);
    assign code_zero  = (code == '0);
    assign entry      = entry_state(mode_in, code_zero);
    assign d_eff      = (divider == '0) ? DIV_W'(1) : divider;
    assign d_last     = d_eff - DIV_W'(1);
    assign gap_last   = GAP_K * {2'b00, d_eff} - (DIV_W+2)'(1);
    // ">=" rather than "==" so a divider shrunk mid-phase ends the phase on the next tick.
    assign phase_done = (cnt >= d_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= CH_IDLE;
            mode_q <= LED_OFF;
            cnt    <= '0;
            blink  <= '0;
            gap    <= '0;
            code_q <= '0;
            lit    <= 1'b0;
        end else if (state == CH_IDLE || mode_in != mode_q || (sync && mode[1])) begin
            mode_q <= mode_in;
            state  <= entry;
            lit    <= state_lit(entry);
            cnt    <= '0;
            blink  <= '0;
            gap    <= '0;
            code_q <= code;
        end else if (tick) begin
            case (state)
                CH_FL_ON, CH_FL_OFF, CH_CD_ON: begin
                    if (phase_done) begin
                        cnt   <= '0;
                        state <= (state == CH_FL_OFF) ? CH_FL_ON
                               : (state == CH_FL_ON)  ? CH_FL_OFF : CH_CD_OFF;
                        lit   <= (state == CH_FL_OFF);
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                CH_CD_OFF: begin
                    if (phase_done) begin
                        cnt <= '0;
                        if ((blink + CODE_W'(1)) >= code_q) begin
                            state <= CH_CD_GAP;
                            gap   <= '0;
                        end else begin
                            blink <= blink + CODE_W'(1);
                            state <= CH_CD_ON;
                            lit   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                // End of the pause, or a parked CODE channel given a non-zero count: new sequence.
                CH_CD_GAP, CH_STEADY_OFF: begin
                    if ((state == CH_CD_GAP && gap >= gap_last) ||
                        (state == CH_STEADY_OFF && mode_q == LED_CODE && !code_zero)) begin
                        cnt    <= '0;
                        gap    <= '0;
                        blink  <= '0;
                        code_q <= code;
                        state  <= code_zero ? CH_STEADY_OFF : CH_CD_ON;
                        lit    <= !code_zero;
                    end else if (state == CH_CD_GAP) begin
                        gap <= gap + (DIV_W+2)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/led_status_bank.sv
// Multi-channel status-LED driver: shared tick prescaler, sync handling and pin polarity
// around NUM_CH independent led_channel pattern generators.
module led_status_bank
    import led_status_bank_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int DIV_W          = 8,
    parameter int CODE_W         = 4,
    parameter int PRESCALE       = 50000,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [2*NUM_CH-1:0]      i_mode,
    input  logic [DIV_W*NUM_CH-1:0]  i_divider,
    input  logic [CODE_W*NUM_CH-1:0] i_code,
    input  logic                     i_sync,
    output logic [NUM_CH-1:0]        o_led,
    output logic                     o_tick
);

    localparam int            PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     pre_cnt;
    logic              tick_q;
    logic [NUM_CH-1:0] lit;

    // A sync restarts the tick period and swallows any tick due on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (i_sync) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            tick_q  <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
            tick_q  <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        led_channel #(
            .DIV_W  (DIV_W),
            .CODE_W (CODE_W)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .mode    (i_mode[2*k +: 2]),
            .divider (i_divider[DIV_W*k +: DIV_W]),
            .code    (i_code[CODE_W*k +: CODE_W]),
            .tick    (tick_q),
            .sync    (i_sync),
            .lit     (lit[k])
        );
    end

    assign o_led  = lit ^ {NUM_CH{LED_ACTIVE_LOW}};
    assign o_tick = tick_q;

endmodule

// File: tb/tb_led_status_bank.sv
// Scoreboarded bench for led_status_bank: a segment-list model predicts every cycle's LEDs and tick
// for an active-high and an active-low instance driven with directed and random stimulus.
module tb_led_status_bank;

    localparam int NUM_CH   = 3;
    localparam int DIV_W    = 8;
    localparam int CODE_W   = 4;
    localparam int PRESCALE = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [2*NUM_CH-1:0]      mode = '0;
    logic [DIV_W*NUM_CH-1:0]  divider = '0;
    logic [CODE_W*NUM_CH-1:0] code = '0;
    logic                     sync = 1'b0;
    logic [NUM_CH-1:0]        led, led_al;
    logic                     tick, tick_al;

    logic [2*NUM_CH-1:0]      cur_mode = '0;
    logic [DIV_W*NUM_CH-1:0]  cur_div = '0;
    logic [CODE_W*NUM_CH-1:0] cur_code = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: each channel walks a list of segments (position + ticks elapsed in it).
    int m_cnt = 0;
    bit m_tick = 1'b0;
    bit m_idle [NUM_CH];
    int m_mode [NUM_CH];
    int m_pos  [NUM_CH];
    int m_el   [NUM_CH];
    int m_n    [NUM_CH];
    bit m_off  [NUM_CH];

    logic [NUM_CH-1:0] exp_led_q [$];
    logic              exp_tick_q [$];

    always #5 clk = ~clk;

    led_status_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CODE_W(CODE_W),
                      .PRESCALE(PRESCALE), .LED_ACTIVE_LOW(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_divider(divider),
        .i_code(code), .i_sync(sync), .o_led(led), .o_tick(tick));

    led_status_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CODE_W(CODE_W),
                      .PRESCALE(PRESCALE), .LED_ACTIVE_LOW(1'b1)) dut_al (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_divider(divider),
        .i_code(code), .i_sync(sync), .o_led(led_al), .o_tick(tick_al));

    function automatic int effDiv(int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int segLen(int ch, int d);
        if (m_mode[ch] == 3 && m_pos[ch] == 2 * m_n[ch]) return 4 * effDiv(d);
        return effDiv(d);
    endfunction

    function automatic bit modelLit(int ch);
        if (m_idle[ch]) return 1'b0;
        case (m_mode[ch])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return m_pos[ch] == 0;
            default: return !m_off[ch] && m_pos[ch] < 2 * m_n[ch] && (m_pos[ch] % 2) == 0;
        endcase
    endfunction

    task automatic startSeq(int ch, int c);
        m_el[ch]  = 0;
        m_pos[ch] = 0;
        m_n[ch]   = c;
        m_off[ch] = (c == 0);
    endtask

    task automatic modelReset();
        m_cnt  = 0;
        m_tick = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_idle[ch] = 1'b1;
            m_mode[ch] = 0;
            startSeq(ch, 0);
        end
    endtask

    task automatic checkOutput(string name, logic [NUM_CH-1:0] actual, logic [NUM_CH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and pushes the outputs the model predicts after the next edge.
    task automatic applyStimulus(logic [2*NUM_CH-1:0] m_in, logic [DIV_W*NUM_CH-1:0] d_in,
                                 logic [CODE_W*NUM_CH-1:0] c_in, logic s_in);
        logic [NUM_CH-1:0] e_led;
        int md, d, c;
        @(negedge clk);
        mode    = m_in;
        divider = d_in;
        code    = c_in;
        sync    = s_in;
        e_led   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            md = int'(m_in[2*ch +: 2]);
            d  = int'(d_in[DIV_W*ch +: DIV_W]);
            c  = int'(c_in[CODE_W*ch +: CODE_W]);
            if (m_idle[ch] || md != m_mode[ch]) begin
                m_idle[ch] = 1'b0;
                m_mode[ch] = md;
                startSeq(ch, c);
            end else if (s_in && md >= 2) begin
                startSeq(ch, c);
            end else if (m_tick && md >= 2) begin
                if (md == 3 && m_off[ch]) begin
                    if (c != 0) startSeq(ch, c);
                end else if (m_el[ch] >= segLen(ch, d) - 1) begin
                    m_el[ch] = 0;
                    m_pos[ch]++;
                    if (md == 2) m_pos[ch] = m_pos[ch] % 2;
                    else if (m_pos[ch] > 2 * m_n[ch]) startSeq(ch, c);
                end else begin
                    m_el[ch]++;
                end
            end
            e_led[ch] = modelLit(ch);
        end
        if (s_in) begin
            m_cnt  = 0;
            m_tick = 1'b0;
        end else if (m_cnt == PRESCALE - 1) begin
            m_cnt  = 0;
            m_tick = 1'b1;
        end else begin
            m_cnt++;
            m_tick = 1'b0;
        end
        exp_led_q.push_back(e_led);
        exp_tick_q.push_back(m_tick);
    endtask

    task automatic runCycles(int n);
        for (int i = 0; i < n; i++) applyStimulus(cur_mode, cur_div, cur_code, 1'b0);
    endtask

    // Monitor: every edge presents a new output word, compared against the oldest prediction.
    always begin
        @(posedge clk);
        #2;
        if (exp_led_q.size() > 0) begin
            logic [NUM_CH-1:0] e_led;
            logic              e_tick;
            e_led  = exp_led_q.pop_front();
            e_tick = exp_tick_q.pop_front();
            checkOutput("led", led, e_led);
            checkOutput("led_active_low", led_al, ~e_led);
            checkOutput("tick", {{(NUM_CH-1){1'b0}}, tick}, {{(NUM_CH-1){1'b0}}, e_tick});
            checkOutput("tick_active_low", {{(NUM_CH-1){1'b0}}, tick_al}, {{(NUM_CH-1){1'b0}}, e_tick});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        modelReset();
        #3;
        checkOutput("reset_led", led, '0);
        checkOutput("reset_led_active_low", led_al, '1);
        checkOutput("reset_tick", {{(NUM_CH-1){1'b0}}, tick}, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        $display("[TB] flash D=3 on ch0/ch2, code 2 D=1 on ch1");
        cur_mode = {2'b10, 2'b11, 2'b10};
        cur_div  = {8'd3, 8'd1, 8'd3};
        cur_code = {4'd0, 4'd2, 4'd0};
        runCycles(120);
        cur_code[CODE_W +: CODE_W] = 4'd0;
        runCycles(60);

        $display("[TB] ch2 flash->on->flash and divider shrink");
        runCycles(14);
        cur_mode[5:4] = 2'b01;
        runCycles(10);
        cur_mode[5:4] = 2'b10;
        runCycles(20);
        cur_div[DIV_W*2 +: DIV_W] = 8'd5;
        runCycles(30);
        cur_div[DIV_W*2 +: DIV_W] = 8'd1;
        runCycles(20);

        $display("[TB] sync coincident with tick");
        cur_mode = {2'b10, 2'b10, 2'b10};
        cur_div  = {8'd4, 8'd2, 8'd3};
        runCycles(37);
        while (m_cnt != PRESCALE - 1) applyStimulus(cur_mode, cur_div, cur_code, 1'b0);
        applyStimulus(cur_mode, cur_div, cur_code, 1'b1);
        runCycles(40);

        $display("[TB] reset mid-flash with modes ON");
        @(negedge clk);
        #1 rst_n = 1'b0;
        cur_mode = {2'b01, 2'b01, 2'b01};
        mode = cur_mode;
        #1;
        checkOutput("async_reset_led", led, '0);
        checkOutput("async_reset_led_active_low", led_al, '1);
        modelReset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        runCycles(5);

        $display("[TB] randomized mode/divider/code/sync");
        for (int s = 0; s < 60; s++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(1, 0) == 1) begin
                    cur_mode[2*ch +: 2]          = 2'($urandom_range(3, 0));
                    cur_div[DIV_W*ch +: DIV_W]   = DIV_W'($urandom_range(4, 0));
                    cur_code[CODE_W*ch +: CODE_W] = CODE_W'($urandom_range(3, 0));
                end else if ($urandom_range(2, 0) == 0) begin
                    cur_div[DIV_W*ch +: DIV_W]   = DIV_W'($urandom_range(5, 0));
                end
            end
            len = $urandom_range(80, 5);
            for (int i = 0; i < len; i++)
                applyStimulus(cur_mode, cur_div, cur_code, $urandom_range(39, 0) == 0);
        end

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
